// File: rtl/inst_fetch_cache.sv
// One-line, direct-fill instruction buffer: hits are served from the local line, misses refill it with one AXI4 INCR burst.
// Optional build macro CRITICAL_WORD_EN: early restart returns the requested word as soon as its beat arrives.
module inst_fetch_cache #(
  parameter int unsigned             ID_WIDTH   = 4,
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 16,
  parameter int unsigned             LINE_WORDS = 128,
  parameter logic [ADDR_WIDTH-1:0]   INST_BASE  = ADDR_WIDTH'(32'h1000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [11:0]           fetch_pc,
  output logic                  busy,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [6:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 11 - OFF_W;
  localparam logic [11:0] LINE_MASK = 12'(LINE_WORDS * 2 - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0] inst_out_q, inst_out_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [6:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  line_valid_q, line_valid_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [OFF_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  served_q, served_d;
  logic                  line_we;
  logic [DATA_WIDTH-1:0] line_q [LINE_WORDS];

  logic [TAG_W-1:0]      pc_tag;
  logic [OFF_W-1:0]      pc_off;
  logic                  unused_in;

  assign pc_tag    = fetch_pc[11:OFF_W+1];
  assign pc_off    = fetch_pc[OFF_W:1];
  assign unused_in = ^{fetch_pc[0], rid, rresp};

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    inst_valid_d = 1'b0;
    inst_out_d   = inst_out_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    line_valid_d = line_valid_q;
    tag_d        = tag_q;
    off_d        = off_q;
    beat_cnt_d   = beat_cnt_q;
    served_d     = served_q;
    line_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          if (line_valid_q && (pc_tag == tag_q)) begin
            inst_valid_d = 1'b1;
            inst_out_d   = line_q[pc_off];
          end else begin
            tag_d        = pc_tag;
            off_d        = pc_off;
            line_valid_d = 1'b0;
            busy_d       = 1'b1;
            araddr_d     = INST_BASE + ADDR_WIDTH'(fetch_pc & ~LINE_MASK);
            arlen_d      = 7'(LINE_WORDS - 1);
            arsize_d     = 3'b001;
            arburst_d    = 2'b01;
            arvalid_d    = 1'b1;
            beat_cnt_d   = '0;
            served_d     = 1'b0;
            state_d      = AR;
          end
        end
      end
      AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (rvalid) begin
          line_we    = 1'b1;
          beat_cnt_d = beat_cnt_q + OFF_W'(1);
`ifdef CRITICAL_WORD_EN
          // Early restart: forward the requested word straight from the bus
          if ((beat_cnt_q == off_q) && !served_q) begin
            inst_valid_d = 1'b1;
            inst_out_d   = rdata;
            busy_d       = 1'b0;
            served_d     = 1'b1;
          end
`endif
          // rlast ends the fill regardless of how many beats were counted
          if (rlast) begin
            rready_d     = 1'b0;
            line_valid_d = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!served_q) begin
          inst_valid_d = 1'b1;
          inst_out_d   = line_q[off_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      line_valid_q <= 1'b0;
      tag_q        <= '0;
      off_q        <= '0;
      beat_cnt_q   <= '0;
      served_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      line_valid_q <= line_valid_d;
      tag_q        <= tag_d;
      off_q        <= off_d;
      beat_cnt_q   <= beat_cnt_d;
      served_q     <= served_d;
    end
  end

  // Line storage needs no reset; line_valid guards its contents
  always_ff @(posedge clk) begin
    if (line_we && !rst) line_q[beat_cnt_q] <= rdata;
  end

  assign busy       = busy_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign arid       = '0;
  assign araddr     = araddr_q;
  assign arlen      = arlen_q;
  assign arsize     = arsize_q;
  assign arburst    = arburst_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;

endmodule
